// File: rtl/keypad_emulator.sv
// Keypad emulator: closes one matrix contact per command and answers the scanner's column drive.
// Optional macro KEYPAD_EMULATOR_BOUNCE_EN adds a contact bounce window at the start of each press.
module keypad_emulator #(
  parameter int RELEASE_GAP   = 16,
  parameter int BOUNCE_CYCLES = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] col,
  output logic [3:0] row,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_key,
  input  logic [7:0] cmd_hold,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS,
    GAP
  } state_t;

  localparam bit PARAMS_OK =
    (RELEASE_GAP >= 1) && (RELEASE_GAP <= 255) &&
    (BOUNCE_CYCLES >= 1) && (BOUNCE_CYCLES <= 255);

  localparam logic [7:0] GAP_LOAD = 8'(RELEASE_GAP - 1);

  generate
    if (!PARAMS_OK) begin : g_bad_params
      $error("keypad_emulator: parameter out of range 1..255");
    end
  endgenerate

  state_t     state;
  state_t     state_nxt;
  logic [7:0] cnt;
  logic [7:0] cnt_nxt;
  logic       done_nxt;
  logic [3:0] key_q;
  logic [3:0] row_nxt;
  logic       accept;
  logic       contact;

  assign accept = cmd_valid && cmd_ready;
  assign busy   = (state != IDLE);

  // Next state and counter reload; cnt holds remaining cycles minus one.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = PRESS;
          cnt_nxt   = (cmd_hold == 8'd0) ? 8'd0 : cmd_hold - 8'd1;
        end
      end
      PRESS: begin
        if (cnt == 8'd0) begin
          state_nxt = GAP;
          cnt_nxt   = GAP_LOAD;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      GAP: begin
        if (cnt == 8'd0) begin
          state_nxt = IDLE;
          cnt_nxt   = 8'd0;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 8'd0;
      end
    endcase
  end

  // State register, hold/gap counter, ready and done flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      done      <= 1'b0;
      cmd_ready <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      done      <= done_nxt;
      cmd_ready <= (state_nxt == IDLE);
    end
  end

  // Key code captured at acceptance; stable for the whole command.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      key_q <= 4'd0;
    end else if (accept) begin
      key_q <= cmd_key;
    end
  end

`ifdef KEYPAD_EMULATOR_BOUNCE_EN
  localparam logic [7:0] BOUNCE_LEN = 8'(BOUNCE_CYCLES);

  logic [7:0] bnc;

  // Offset into PRESS, saturating once the bounce window is over.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bnc <= 8'd0;
    end else if (accept) begin
      bnc <= 8'd0;
    end else if (state == PRESS && bnc < BOUNCE_LEN) begin
      bnc <= bnc + 8'd1;
    end
  end

  // Inside the window the contact only closes on even offsets.
  assign contact = (state == PRESS) &&
                   ((bnc >= BOUNCE_LEN) || !bnc[0]);
`else
  assign contact = (state == PRESS);
`endif

  // Only the pressed key's row can be pulled low, and only if its column is driven.
  always_comb begin
    row_nxt = 4'hF;
    if (contact && !col[key_q[1:0]]) begin
      row_nxt[key_q[3:2]] = 1'b0;
    end
  end

  // Row sense is registered: one cycle from col to row.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row <= 4'hF;
    end else begin
      row <= row_nxt;
    end
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench for keypad_emulator: press timing, row sense, back-to-back commands, reset abort.
// Expected contact pattern follows KEYPAD_EMULATOR_BOUNCE_EN when that macro is defined.
module tb_keypad_emulator;

  localparam int GAP    = 16;
  localparam int BOUNCE = 8;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] col;
  logic [3:0] row;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_key;
  logic [7:0] cmd_hold;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  keypad_emulator #(
    .RELEASE_GAP  (GAP),
    .BOUNCE_CYCLES(BOUNCE)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .col      (col),
    .row      (row),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_key  (cmd_key),
    .cmd_hold (cmd_hold),
    .busy     (busy),
    .done     (done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit closed(input int off);
`ifdef KEYPAD_EMULATOR_BOUNCE_EN
    return (off >= BOUNCE) || (off % 2 == 0);
`else
    return off >= 0;
`endif
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Issue one command from IDLE and follow it through PRESS, GAP and done.
  task automatic press(input logic [3:0] key, input logic [7:0] h,
                       input logic [3:0] colv, input logic [3:0] rlow);
    int he;
    int dk;
    logic [3:0] er;
    he = (h == 8'd0) ? 1 : int'(h);
    dk = -1;
    col       = colv;
    cmd_key   = key;
    cmd_hold  = h;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("p0_row", 32'(row), 32'hF);
    check("p0_busy", 32'(busy), 32'd1);
    check("p0_ready", 32'(cmd_ready), 32'd0);
    for (int k = 1; k <= he + GAP + 1; k++) begin
      tick();
      er = (k <= he && closed(k - 1)) ? rlow : 4'hF;
      check($sformatf("row_k%0d", k), 32'(row), 32'(er));
      if (done && dk < 0) dk = k;
    end
    check("done_at", 32'(dk), 32'(he + GAP));
    check("end_ready", 32'(cmd_ready), 32'd1);
    check("end_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    col       = 4'hF;
    cmd_valid = 1'b0;
    cmd_key   = 4'd0;
    cmd_hold  = 8'd0;
    repeat (3) tick();
    check("rst_row", 32'(row), 32'hF);
    check("rst_ready", 32'(cmd_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);

    reset = 1'b0;
    tick();
    check("ready_after_rst", 32'(cmd_ready), 32'd1);

    col = 4'h0;
    tick();
    check("idle_row_open", 32'(row), 32'hF);

    // key 5 = row 1, column 1
    press(4'd5, 8'd20, 4'b1101, 4'b1101);
    press(4'd5, 8'd20, 4'b1110, 4'hF);
    // key F = row 3, column 3, full sweep
    press(4'hF, 8'd3, 4'b0000, 4'b0111);
    // zero hold gives a single closed cycle
    press(4'd6, 8'd0, 4'b1011, 4'b1101);
`ifdef KEYPAD_EMULATOR_BOUNCE_EN
    press(4'd0, 8'd12, 4'b0000, 4'b1110);
`endif

    // cmd_valid held high: second accept lands in the done cycle
    col       = 4'b0000;
    cmd_key   = 4'd0;
    cmd_hold  = 8'd0;
    cmd_valid = 1'b1;
    tick();
    for (int k = 0; k <= 2 * (GAP + 2) - 1; k++) begin
      if (k > 0) tick();
      check($sformatf("b2b_ready_k%0d", k), 32'(cmd_ready),
            32'(k == GAP + 1 || k == 2 * GAP + 3));
      check($sformatf("b2b_done_k%0d", k), 32'(done),
            32'(k == GAP + 1 || k == 2 * GAP + 3));
      if (k == 1 || k == GAP + 3)
        check($sformatf("b2b_row_k%0d", k), 32'(row), 32'hE);
      if (k == 2 || k == GAP + 4)
        check($sformatf("b2b_row_k%0d", k), 32'(row), 32'hF);
    end
    cmd_valid = 1'b0;
    tick();
    check("b2b_idle", 32'(busy), 32'd0);

    // reset pulsed during the 5th PRESS cycle
    col       = 4'b1101;
    cmd_key   = 4'd5;
    cmd_hold  = 8'd20;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    repeat (4) tick();
    check("pre_abort_busy", 32'(busy), 32'd1);
    check("pre_abort_row", 32'(row), 32'(closed(3) ? 4'b1101 : 4'hF));
    #2;
    reset = 1'b1;
    #1;
    check("abort_row", 32'(row), 32'hF);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ready", 32'(cmd_ready), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    #1;
    reset = 1'b0;
    tick();
    check("post_abort_ready", 32'(cmd_ready), 32'd1);
    check("post_abort_done", 32'(done), 32'd0);
    check("post_abort_row", 32'(row), 32'hF);
    for (int k = 0; k < GAP + 4; k++) begin
      tick();
      if (done) check("no_done_after_abort", 32'(done), 32'd0);
    end
    check("post_abort_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
